pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 2: pipeline depth; SHALL divide WIDTH exactly; CHUNK = WIDTH/STAGES bits are added per stage.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  input operands valid.
REQ-006 s_ready  output  1  block accepts operands this cycle.
REQ-007 s_a, s_b  input  WIDTH  operands.
REQ-008 s_ci  input  1  carry-in; used in add mode only.
REQ-009 s_sub  input  1  0 = add, 1 = subtract.
REQ-010 m_valid  output  1  result valid.
REQ-011 m_ready  input  1  downstream accepts result.
REQ-012 m_sum  output  WIDTH  result.
REQ-013 m_co  output  1  carry-out of bit WIDTH-1.
REQ-014 m_ovf  output  1  two's-complement signed overflow.

Function
REQ-015 Add mode SHALL compute {m_co, m_sum} = s_a + s_b + s_ci, modulo 2^(WIDTH+1).
REQ-016 Subtract mode SHALL compute s_a + ~s_b + 1; s_ci is ignored; m_co = 1 means no borrow.
REQ-017 m_ovf SHALL be 1 iff both effective operands (s_a and b_eff, where b_eff = ~s_b in subtract mode) have the same MSB and m_sum MSB differs from it.
REQ-018 Stage k (k = 0..STAGES-1) SHALL add chunk k of s_a and b_eff plus the registered carry from stage k-1; stage 0 takes the carry-in.
REQ-019 Upper operand chunks and completed lower sum chunks SHALL be carried forward in registers alongside each stage.
REQ-020 Only one CHUNK-bit carry chain SHALL exist per stage; no full-WIDTH combinational adder.
REQ-021 Define advance = !m_valid | m_ready; s_ready SHALL equal advance (combinational).
REQ-022 When advance = 1, every stage SHALL shift one position, and stage 0 SHALL load valid = s_valid & s_ready.
REQ-023 When advance = 0, all stage registers, m_valid, m_sum, m_co and m_ovf SHALL hold.
REQ-024 Latency SHALL be exactly STAGES cycles from acceptance (s_valid & s_ready) to m_valid, with no stall.
REQ-025 Throughput SHALL be one result per cycle while m_ready = 1.
REQ-026 Bubbles SHALL propagate unchanged; they are not collapsed.
REQ-027 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-028 A result SHALL be consumed only on a cycle where m_valid & m_ready = 1.
REQ-029 Data outputs when m_valid = 0 are don't-care for checking, but SHALL be deterministic (registered).
REQ-030 STAGES = 1 SHALL give a single registered full-width add with latency 1.

Reset
REQ-031 While rst = 1 at a clock edge, all stage valid bits and m_valid SHALL clear to 0.
REQ-032 While rst = 1, m_sum, m_co and m_ovf SHALL reset to 0.
REQ-033 During reset, s_ready SHALL follow REQ-021, giving 1 after the edge.
REQ-034 Reset mid-operation SHALL discard all in-flight operands; no stale result SHALL appear afterwards.
REQ-035 Inputs presented in the same cycle as rst = 1 SHALL be ignored.

Verification (WIDTH=8, STAGES=2, m_ready=1 unless stated)
REQ-036 Carry across chunks: a=0xFF, b=0x01, ci=0, sub=0 -> 2 cycles later m_valid=1, sum=0x00, co=1, ovf=0.
REQ-037 Signed overflow: a=0x7F, b=0x01, ci=0 -> sum=0x80, co=0, ovf=1. Carry-in: a=0x0F, b=0x00, ci=1 -> sum=0x10, co=0, ovf=0.
REQ-038 Subtract with borrow: a=0x05, b=0x07, sub=1, ci=1 -> sum=0xFE, co=0, ovf=0. Subtract with overflow: a=0x80, b=0x01, sub=1 -> sum=0x7F, co=1, ovf=1.
REQ-039 Backpressure: issue 3 back-to-back ops with m_ready=0 -> s_ready drops after the pipe fills; m_valid and the first result stay stable. Raise m_ready -> all 3 results emerge in order, one per cycle.
REQ-040 Reset mid-flight: accept 2 ops, assert rst for 1 cycle -> m_valid=0 and sum=0x00 after the edge; no result from those ops ever appears.
REQ-041 Random streaming: 10k random operands and modes with random s_valid/m_ready -> every result matches the REQ-015..017 reference model, in order, with no loss.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor with a valid/ready stream on each side.
// Each stage ripples one CHUNK-bit slice and hands its carry to the next stage.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic             s_ci,
  input  logic             s_sub,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_sum,
  output logic             m_co,
  output logic             m_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             w_advance;

  // Stage-boundary buses: index k carries the inputs seen by stage k.
  logic             w_vld [STAGES];
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic [WIDTH-1:0] w_sum [STAGES];
  logic             w_cy  [STAGES];

  assign w_advance = !m_valid || m_ready;
  assign s_ready   = w_advance;

  assign w_vld[0] = s_valid & w_advance;
  assign w_a[0]   = s_a;
  assign w_b[0]   = s_sub ? ~s_b : s_b;
  assign w_cy[0]  = s_sub ? 1'b1 : s_ci;
  assign w_sum[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0]   w_chunk;
    logic [WIDTH-1:0] w_sum_next;

    assign w_chunk = {1'b0, w_a[k][k*CHUNK +: CHUNK]}
                   + {1'b0, w_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, w_cy[k]};

    always_comb begin
      w_sum_next = w_sum[k];
      w_sum_next[k*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
    end

    if (k == STAGES - 1) begin : g_out
      always_ff @(posedge clk) begin
        if (rst) begin
          m_valid <= 1'b0;
          m_sum   <= '0;
          m_co    <= 1'b0;
          m_ovf   <= 1'b0;
        end else if (w_advance) begin
          m_valid <= w_vld[k];
          m_sum   <= w_sum_next;
          m_co    <= w_chunk[CHUNK];
          m_ovf   <= (w_a[k][WIDTH-1] == w_b[k][WIDTH-1]) &&
                     (w_sum_next[WIDTH-1] != w_a[k][WIDTH-1]);
        end
      end
    end else begin : g_mid
      logic             r_vld;
      logic             r_cy;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_sum;

      // NOTE: data registers are reset as well as the valid bit so that bubbles
      // never shift X into the registered outputs.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld <= 1'b0;
          r_cy  <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
          r_sum <= '0;
        end else if (w_advance) begin
          r_vld <= w_vld[k];
          r_cy  <= w_chunk[CHUNK];
          r_a   <= w_a[k];
          r_b   <= w_b[k];
          r_sum <= w_sum_next;
        end
      end

      assign w_vld[k+1] = r_vld;
      assign w_cy[k+1]  = r_cy;
      assign w_a[k+1]   = r_a;
      assign w_b[k+1]   = r_b;
      assign w_sum[k+1] = r_sum;
    end
  end

endmodule
